// File: rtl/jstk_spi_responder.sv
// SPI mode-0 responder emulating the PmodJSTK end of the joystick link.
// Optional JSTK_CMD_CHECK_EN: reject command bytes not of the form 6'b100000_xx.
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int POS_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss_n,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [POS_W-1:0] x_pos,
  input  logic [POS_W-1:0] y_pos,
  input  logic [2:0]       btn,
  output logic [1:0]       led,
  output logic             frame_done,
  output logic             frame_err
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic ss_s, sclk_s, mosi_s;
  logic ss_q, sclk_q;
  logic ss_fall, ss_rise;
  logic sclk_rise, sclk_fall;

  logic [POS_W-1:0] x_q, y_q;
  logic [2:0]       btn_q;
  logic [7:0]       tx_sr;
  logic [6:0]       rx_sr;
  logic [7:0]       cmd_reg;
  logic [3:0]       bit_cnt;
  logic [2:0]       byte_idx;
  logic [2:0]       nxt_idx;
  logic [7:0]       nxt_byte;
  logic [7:0]       first_byte;

  logic complete, cmd_ok;
  logic done_d, err_d, led_upd;

  function automatic logic [7:0] frame_byte(
    input logic [2:0] idx,
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [2:0] b
  );
    case (idx)
      3'd0:    frame_byte = x[7:0];
      3'd1:    frame_byte = {6'b0, x[9:8]};
      3'd2:    frame_byte = y[7:0];
      3'd3:    frame_byte = {6'b0, y[9:8]};
      3'd4:    frame_byte = {5'b0, b};
      default: frame_byte = 8'h00;
    endcase
  endfunction

  // Newest sample enters at bit 0, synchronized copy leaves the top bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_q      <= 1'b1;
      sclk_q    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_q      <= ss_s;
      sclk_q    <= sclk_s;
    end
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_fall   = ss_q & ~ss_s;
  assign ss_rise   = ~ss_q & ss_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign sclk_fall = sclk_q & ~sclk_s;

  assign nxt_idx    = (byte_idx == 3'd7) ? 3'd7 : 3'(byte_idx + 3'd1);
  assign nxt_byte   = frame_byte(nxt_idx, 10'(x_q), 10'(y_q), btn_q);
  assign first_byte = frame_byte(3'd0, 10'(x_pos), 10'(y_pos), btn);

  assign complete = ((byte_idx >= 3'd4) && (bit_cnt == 4'd8)) ||
                    (byte_idx >= 3'd5);

`ifdef JSTK_CMD_CHECK_EN
  assign cmd_ok = (cmd_reg[7:2] == 6'b100000);
`else
  logic unused_cmd;
  assign unused_cmd = ^cmd_reg[7:2];
  assign cmd_ok     = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    err_d   = 1'b0;
    led_upd = 1'b0;
    unique case (state)
      IDLE: if (ss_fall) state_d = XFER;
      XFER: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (complete && cmd_ok) begin
            done_d  = 1'b1;
            led_upd = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ss_n rise takes priority over any sclk edge seen on the same clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      led        <= 2'b00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      btn_q      <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      cmd_reg    <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
    end else begin
      frame_done <= done_d;
      frame_err  <= err_d;
      if (led_upd) led <= cmd_reg[1:0];
      if (state == IDLE) begin
        if (ss_fall) begin
          x_q      <= x_pos;
          y_q      <= y_pos;
          btn_q    <= btn;
          tx_sr    <= first_byte;
          miso     <= first_byte[7];
          miso_oe  <= 1'b1;
          bit_cnt  <= '0;
          byte_idx <= '0;
        end
      end else if (ss_rise) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else if (sclk_rise) begin
        rx_sr <= {rx_sr[5:0], mosi_s};
        if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
        if (byte_idx == 3'd0 && bit_cnt == 4'd7)
          cmd_reg <= {rx_sr, mosi_s};
      end else if (sclk_fall) begin
        if (bit_cnt == 4'd8) begin
          byte_idx <= nxt_idx;
          bit_cnt  <= '0;
          tx_sr    <= nxt_byte;
          miso     <= nxt_byte[7];
        end else begin
          tx_sr <= {tx_sr[6:0], 1'b0};
          miso  <= tx_sr[6];
        end
      end
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: 1 MHz SPI initiator model,
// frame/abort/overrun/command-check/reset scenarios.
module tb_jstk_spi_responder;

  localparam int SYNC_STAGES = 2;
  localparam int POS_W       = 10;
  localparam int HALF        = 50;

  logic             clk = 1'b0;
  logic             rst;
  logic             ss_n, sclk, mosi;
  logic             miso, miso_oe;
  logic [POS_W-1:0] x_pos, y_pos;
  logic [2:0]       btn;
  logic [1:0]       led;
  logic             frame_done, frame_err;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int d0, e0;
  int chg_at;
  logic [7:0] rx [0:6];
  logic [7:0] tmp;

  jstk_spi_responder #(
    .SYNC_STAGES(SYNC_STAGES),
    .POS_W      (POS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ss_n      (ss_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .btn       (btn),
    .led       (led),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      wait_clk(HALF);
      r[i] = miso;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int nb);
    d0   = done_cnt;
    e0   = err_cnt;
    ss_n = 1'b0;
    wait_clk(4);
    for (int b = 0; b < nb; b++) begin
      if (b == chg_at) x_pos = '0;
      xfer((b == 0) ? cmd : 8'h00, rx[b]);
    end
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(10);
  endtask

  initial begin
    rst    = 1'b0;
    ss_n   = 1'b1;
    sclk   = 1'b0;
    mosi   = 1'b0;
    x_pos  = '0;
    y_pos  = '0;
    btn    = '0;
    chg_at = -1;
    wait_clk(5);
    chk("rst_miso", 8'(miso), 8'h0);
    chk("rst_oe", 8'(miso_oe), 8'h0);
    chk("rst_led", 8'(led), 8'h0);
    chk("rst_done", 8'(frame_done), 8'h0);
    chk("rst_err", 8'(frame_err), 8'h0);

    rst = 1'b1;
    d0  = done_cnt;
    e0  = err_cnt;
    wait_clk(100);
    chk("idle_done", 8'(done_cnt - d0), 8'h0);
    chk("idle_err", 8'(err_cnt - e0), 8'h0);

    x_pos = 10'h2A5;
    y_pos = 10'h0F3;
    btn   = 3'b101;
    run_frame(8'h81, 5);
    chk("full_b0", rx[0], 8'hA5);
    chk("full_b1", rx[1], 8'h02);
    chk("full_b2", rx[2], 8'hF3);
    chk("full_b3", rx[3], 8'h00);
    chk("full_b4", rx[4], 8'h05);
    chk("full_done", 8'(done_cnt - d0), 8'h1);
    chk("full_err", 8'(err_cnt - e0), 8'h0);
    chk("full_led", 8'(led), 8'h1);
    chk("full_oe_off", 8'(miso_oe), 8'h0);
    chk("full_miso_off", 8'(miso), 8'h0);

    chg_at = 1;
    run_frame(8'h81, 5);
    chg_at = -1;
    chk("snap_b0", rx[0], 8'hA5);
    chk("snap_b1", rx[1], 8'h02);
    chk("snap_done", 8'(done_cnt - d0), 8'h1);

    d0   = done_cnt;
    e0   = err_cnt;
    ss_n = 1'b0;
    wait_clk(4);
    chk("abort_oe_on", 8'(miso_oe), 8'h1);
    xfer(8'h82, tmp);
    chk("abort_b0", tmp, 8'h00);
    xfer(8'h00, tmp);
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(SYNC_STAGES + 1);
    chk("abort_oe_off", 8'(miso_oe), 8'h0);
    chk("abort_miso", 8'(miso), 8'h0);
    wait_clk(10);
    chk("abort_err", 8'(err_cnt - e0), 8'h1);
    chk("abort_done", 8'(done_cnt - d0), 8'h0);
    chk("abort_led", 8'(led), 8'h1);

    run_frame(8'h81, 7);
    chk("ovr_b2", rx[2], 8'hF3);
    chk("ovr_b4", rx[4], 8'h05);
    chk("ovr_b5", rx[5], 8'h00);
    chk("ovr_b6", rx[6], 8'h00);
    chk("ovr_done", 8'(done_cnt - d0), 8'h1);
    chk("ovr_err", 8'(err_cnt - e0), 8'h0);

    run_frame(8'h43, 5);
    chk("c43_b2", rx[2], 8'hF3);
`ifdef JSTK_CMD_CHECK_EN
    chk("c43_err", 8'(err_cnt - e0), 8'h1);
    chk("c43_done", 8'(done_cnt - d0), 8'h0);
    chk("c43_led", 8'(led), 8'h1);
`else
    chk("c43_err", 8'(err_cnt - e0), 8'h0);
    chk("c43_done", 8'(done_cnt - d0), 8'h1);
    chk("c43_led", 8'(led), 8'h3);
`endif

    run_frame(8'h82, 5);
    chk("c82_done", 8'(done_cnt - d0), 8'h1);
    chk("c82_led", 8'(led), 8'h2);

    d0   = done_cnt;
    e0   = err_cnt;
    ss_n = 1'b0;
    wait_clk(4);
    xfer(8'h81, tmp);
    rst = 1'b0;
    wait_clk(1);
    chk("mid_rst_led", 8'(led), 8'h0);
    chk("mid_rst_oe", 8'(miso_oe), 8'h0);
    chk("mid_rst_miso", 8'(miso), 8'h0);
    ss_n = 1'b1;
    wait_clk(5);
    rst = 1'b1;
    wait_clk(20);
    chk("mid_rst_done", 8'(done_cnt - d0), 8'h0);
    chk("mid_rst_err", 8'(err_cnt - e0), 8'h0);

    y_pos = 10'h3C4;
    btn   = 3'b010;
    run_frame(8'h81, 5);
    chk("post_b0", rx[0], 8'h00);
    chk("post_b2", rx[2], 8'hC4);
    chk("post_b3", rx[3], 8'h03);
    chk("post_b4", rx[4], 8'h02);
    chk("post_led", 8'(led), 8'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
